// File: rtl/ram_cmd_arbiter_if.sv
// ram_cmd_arbiter_if
// One ram_cmd / ram_rd_resp handshake bundle that is N lanes wide. Lane k of
// every bus sits at [k*WIDTH +: WIDTH]. The requester side of the arbiter
// uses N = PORTS. The RAM side uses N = 1.
//   cmd_id/addr/wr_data/wr_strb  : command fields, master -> slave
//   cmd_wr_en/rd_en/last         : command qualifiers, master -> slave
//   cmd_ready                    : command accepted, slave -> master
//   rd_resp_id/data/last/valid   : read response, slave -> master
//   rd_resp_ready                : response accepted, master -> slave
interface ram_cmd_arbiter_if #(
  parameter int N          = 1,
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [N*ID_WIDTH-1:0]   cmd_id;
  logic [N*ADDR_WIDTH-1:0] cmd_addr;
  logic [N*DATA_WIDTH-1:0] cmd_wr_data;
  logic [N*STRB_WIDTH-1:0] cmd_wr_strb;
  logic [N-1:0]            cmd_wr_en;
  logic [N-1:0]            cmd_rd_en;
  logic [N-1:0]            cmd_last;
  logic [N-1:0]            cmd_ready;
  logic [N*ID_WIDTH-1:0]   rd_resp_id;
  logic [N*DATA_WIDTH-1:0] rd_resp_data;
  logic [N-1:0]            rd_resp_last;
  logic [N-1:0]            rd_resp_valid;
  logic [N-1:0]            rd_resp_ready;

  modport master (
    output cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
    output rd_resp_ready,
    input  cmd_ready, rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid
  );

  modport slave (
    input  cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
    input  rd_resp_ready,
    output cmd_ready, rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid
  );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
// Shares one RAM command / read-response port among PORTS requesters.
// Round-robin grant with burst lock: a port keeps the RAM until the beat
// carrying cmd_last is accepted. Read responses are routed back in issue
// order through a small FIFO of port indices.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   s_ram  : requester side (slave modport, PORTS lanes)
//   m_ram  : RAM side (master modport, 1 lane)
// Build option:
//   RAM_CMD_ARB_FIXED_PRIO_EN : when defined, the lowest-index requesting
//   port wins in IDLE and the round-robin pointer is removed. Burst lock and
//   response routing are unchanged.
module ram_cmd_arbiter #(
  parameter int PORTS           = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_cmd_arbiter_if.slave  s_ram,
  ram_cmd_arbiter_if.master m_ram
);
  localparam int PTR_W   = $clog2(PORTS);
  localparam int FIFO_AW = $clog2(RESP_FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  typedef logic [PTR_W-1:0] port_t;

  state_t             r_state;
  port_t              r_grant;
  port_t              r_fifo [RESP_FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic [PORTS-1:0] w_req;
  port_t            w_pick;
  logic             w_any_req;
  port_t            w_grant;
  logic             w_gvalid;
  logic             w_g_rd, w_g_wr, w_g_req, w_g_last;
  logic             w_fifo_empty, w_fifo_full;
  port_t            w_head;
  logic             w_pop, w_push, w_rd_blocked, w_cmd_ok, w_accept;

  assign w_req = s_ram.cmd_wr_en | s_ram.cmd_rd_en;

`ifdef RAM_CMD_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise a path
    // that assigns nothing would infer a latch.
    w_pick    = '0;
    w_any_req = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_pick    = port_t'(i);
        w_any_req = 1'b1;
      end
    end
  end
`else
  port_t r_rr_ptr;

  function automatic port_t wrap_add(input port_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= PORTS) s = s - PORTS;
    return port_t'(s);
  endfunction

  // Offsets are scanned from the far end toward rr_ptr, so the requester
  // nearest rr_ptr (searching upward with wrap) is the last one written.
  always_comb begin
    w_pick    = '0;
    w_any_req = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (w_req[wrap_add(r_rr_ptr, i)]) begin
        w_pick    = wrap_add(r_rr_ptr, i);
        w_any_req = 1'b1;
      end
    end
  end
`endif

  // Reset gates the grant combinationally so nothing is accepted or routed
  // during the reset cycle itself.
  assign w_grant  = (r_state == ST_LOCKED) ? r_grant : w_pick;
  assign w_gvalid = !rst && ((r_state == ST_LOCKED) || w_any_req);
  assign w_g_rd   = s_ram.cmd_rd_en[w_grant];
  assign w_g_wr   = s_ram.cmd_wr_en[w_grant];
  assign w_g_req  = w_req[w_grant];
  assign w_g_last = s_ram.cmd_last[w_grant];

  // Response routing: the FIFO head names the port owed the next response.
  // With nothing outstanding, a stray response is drained and dropped.
  assign w_fifo_empty = rst || (r_count == '0);
  assign w_fifo_full  = (r_count == (FIFO_AW + 1)'(RESP_FIFO_DEPTH));
  assign w_head       = r_fifo[r_rd_ptr];

  assign m_ram.rd_resp_ready = w_fifo_empty ? m_ram.rd_resp_valid
                                            : s_ram.rd_resp_ready[w_head];
  assign w_pop = m_ram.rd_resp_valid && m_ram.rd_resp_ready && !w_fifo_empty;

  assign s_ram.rd_resp_id    = {PORTS{m_ram.rd_resp_id}};
  assign s_ram.rd_resp_data  = {PORTS{m_ram.rd_resp_data}};
  assign s_ram.rd_resp_last  = {PORTS{m_ram.rd_resp_last}};
  assign s_ram.rd_resp_valid = (m_ram.rd_resp_valid && !w_fifo_empty)
                               ? (PORTS'(1) << w_head) : '0;

  // A read may enter a full FIFO only when an entry leaves in the same cycle.
  assign w_rd_blocked = w_g_rd && w_fifo_full && !w_pop;
  assign w_cmd_ok     = w_gvalid && !w_rd_blocked && m_ram.cmd_ready;
  assign w_accept     = w_cmd_ok && w_g_req;
  assign w_push       = w_accept && w_g_rd;

  assign s_ram.cmd_ready     = w_cmd_ok ? (PORTS'(1) << w_grant) : '0;
  assign m_ram.cmd_wr_en     = w_gvalid && w_g_wr;
  assign m_ram.cmd_rd_en     = w_gvalid && w_g_rd && !w_rd_blocked;
  assign m_ram.cmd_last      = w_g_last;
  assign m_ram.cmd_id        = s_ram.cmd_id[w_grant*ID_WIDTH +: ID_WIDTH];
  assign m_ram.cmd_addr      = s_ram.cmd_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_ram.cmd_wr_data   = s_ram.cmd_wr_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_ram.cmd_wr_strb   = s_ram.cmd_wr_strb[w_grant*STRB_WIDTH +: STRB_WIDTH];

  // NOTE: the index storage has no reset; an entry is only read after it has
  // been pushed, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_grant;
  end

  // Lock state, round-robin pointer and FIFO pointers.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the values from before this edge, independent of statement order.
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
`ifndef RAM_CMD_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        if (w_g_last) begin
          r_state  <= ST_IDLE;
`ifndef RAM_CMD_ARB_FIXED_PRIO_EN
          r_rr_ptr <= wrap_add(w_grant, 1);
`endif
        end else begin
          r_state <= ST_LOCKED;
          r_grant <= w_grant;
        end
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares one RAM command/read-response port among PORTS requesters that all use the codebase's ram_cmd / ram_rd_resp handshake.
- Sits between several axi_ram_wr_rd_if-style front ends and a single RAM core, such as one port of the dual-port RAM.
- Round-robin arbitration with burst lock: a granted requester keeps the RAM until its beat with cmd_last is accepted.
- Read responses are routed back in issue order through an internal port-index FIFO.

Parameters:
- PORTS, 2: number of requesters (2..8).
- DATA_WIDTH, 32: data bus width.
- ADDR_WIDTH, 16: byte address width.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.
- ID_WIDTH, 8: command/response ID width.
- RESP_FIFO_DEPTH, 4: outstanding read beats tracked (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_ram_cmd_id  in  PORTS*ID_WIDTH  per-requester ID, port k at [k*ID_WIDTH +: ID_WIDTH]; other s_* buses are sliced the same way
- s_ram_cmd_addr  in  PORTS*ADDR_WIDTH  per-requester address
- s_ram_cmd_wr_data  in  PORTS*DATA_WIDTH  per-requester write data
- s_ram_cmd_wr_strb  in  PORTS*STRB_WIDTH  per-requester strobes
- s_ram_cmd_wr_en  in  PORTS  write request
- s_ram_cmd_rd_en  in  PORTS  read request
- s_ram_cmd_last  in  PORTS  last beat of burst
- s_ram_cmd_ready  out  PORTS  command accepted
- s_ram_rd_resp_id  out  PORTS*ID_WIDTH  routed response ID
- s_ram_rd_resp_data  out  PORTS*DATA_WIDTH  routed response data
- s_ram_rd_resp_last  out  PORTS  routed response last
- s_ram_rd_resp_valid  out  PORTS  routed response valid
- s_ram_rd_resp_ready  in  PORTS  requester response ready
- m_ram_cmd_id/addr/wr_data/wr_strb  out  ID_WIDTH/ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH  to RAM
- m_ram_cmd_wr_en, m_ram_cmd_rd_en, m_ram_cmd_last  out  1  to RAM
- m_ram_cmd_ready  in  1  RAM command ready
- m_ram_rd_resp_id/data/last/valid  in  ID_WIDTH/DATA_WIDTH/1/1  from RAM
- m_ram_rd_resp_ready  out  1  to RAM

Behaviour:
- Request: req[k] = s_ram_cmd_wr_en[k] | s_ram_cmd_rd_en[k]. A beat is accepted when the granted port's req, s_ram_cmd_ready and m_ram_cmd_ready are all high.
- States: IDLE, LOCKED. Registers: grant_reg, rr_ptr, lock state, response FIFO.
- IDLE:
  - Grant is chosen combinationally, zero added latency: the first requesting port searching upward from rr_ptr, wrapping.
  - The granted port's fields are muxed to m_*. m_ram_cmd_wr_en/rd_en are masked by the grant; all other s_ram_cmd_ready bits are 0.
- Accepted beat in IDLE:
  - last=0 -> LOCKED, grant_reg=granted port.
  - last=1 -> stay IDLE, rr_ptr=granted+1 mod PORTS.
- LOCKED:
  - Only grant_reg is passed through, even if other ports request.
  - Accepted beat with last=1 -> IDLE, rr_ptr=grant_reg+1 mod PORTS.
  - Deasserting req mid-burst holds the lock (no timeout).
- No request in IDLE: m_ram_cmd_wr_en=m_ram_cmd_rd_en=0, rr_ptr unchanged.
- Read gating:
  - Granted read beat is blocked (m_ram_cmd_rd_en=0, s_ram_cmd_ready=0) while the response FIFO is full.
  - Write beats are never gated by the FIFO.
- Response FIFO:
  - Each accepted read beat pushes the granted port index.
  - Head index routes the response: s_ram_rd_resp_valid[head]=m_ram_rd_resp_valid, m_ram_rd_resp_ready=s_ram_rd_resp_ready[head].
  - Pop on m_ram_rd_resp_valid & m_ram_rd_resp_ready.
  - Push and pop in the same cycle keep the count constant; pop-then-push is allowed when full.
- Response arriving with the FIFO empty (protocol violation): m_ram_rd_resp_ready=1, beat discarded, no s_* valid asserted.
- ID/data/last are broadcast to every s_ram_rd_resp_* slice; only valid is per-port.
- Reset values:
  - All s_ram_cmd_ready=0, all s_ram_rd_resp_valid=0.
  - m_ram_cmd_wr_en=m_ram_cmd_rd_en=0; m_ram_rd_resp_ready=0 unless a response is pending on an empty FIFO.
  - State=IDLE, rr_ptr=0, FIFO empty.
- Reset mid-burst abandons the lock and flushes the FIFO. Bursts and responses are not completed.

Optional Feature:
RAM_CMD_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest-index requesting port wins in IDLE; rr_ptr is removed. Burst lock and FIFO behaviour are unchanged.
- Undefined: round-robin as above.

Test Plan:
- PORTS=2, both ports issue single-beat writes (last=1) every cycle, m_ram_cmd_ready=1 -> grants alternate 0,1,0,1; addresses appear on m_ram_cmd_addr in that order, one per cycle.
- Port 0 write burst of 4 beats with port 1 requesting throughout -> 4 consecutive port-0 beats, then port 1 is granted in the cycle after last is accepted.
- Ports 0,1,0 issue single reads with IDs 0x11,0x22,0x33; RAM returns in order -> valid routed to port 0, then 1, then 0 with matching IDs; FIFO empty at end.
- RESP_FIFO_DEPTH=4, 5 reads issued with m_ram_rd_resp_ready held off by s_ram_rd_resp_ready=0 -> 5th read stalls (ready=0) until one response pops; a concurrent write from the other port is still accepted.
- Assert rst during beat 2 of a port-1 burst with 2 reads outstanding -> next cycle all s_ram_cmd_ready=0, all rd_resp_valid=0, IDLE; a subsequent port-0 request is granted immediately.
- Build with RAM_CMD_ARB_FIXED_PRIO_EN, ports 0 and 1 both issue continuous single writes -> port 0 granted every cycle, port 1 starved.
